// File: rtl/midi_key_rx.sv
// MIDI serial receiver and two-key note tracker: 8N1 UART front end feeding a
// running-status note-on/off parser that holds up to two sounding notes.
module midi_key_rx #(
    parameter int CLKS_PER_BIT = 2080,
    parameter int CHANNEL      = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       midi_in,
    output logic [6:0] key1_index,
    output logic [6:0] key2_index,
    output logic       midi_ready,
    output logic       frame_err
);

    localparam int              CW      = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]   FULL_TC = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
    localparam bit              OMNI    = (CHANNEL > 15);
    localparam logic [3:0]      CH_NIB  = 4'(CHANNEL);

    // state       | meaning
    // S_IDLE      | line idle, waiting for a synchronized falling edge
    // S_START     | timing to the middle of the start bit
    // S_DATA      | sampling 8 data bits, LSB first
    // S_STOP      | sampling the stop bit
    // S_WAIT_HIGH | after a framing error, waiting for the line to go high
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } uart_state_t;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_ON,
        CMD_OFF
    } cmd_t;

    logic          sync1_q, sync2_q, sync3_q;
    uart_state_t   state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic [7:0]    rx_byte_q;
    logic          rx_valid_q;
    logic          frame_err_q;

    // sync3_q is only the previous synchronized value, used for edge detection
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            sync3_q     <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= midi_in;
            sync2_q     <= sync1_q;
            sync3_q     <= sync2_q;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (sync3_q && !sync2_q) begin
                        state_q <= S_START;
                        cnt_q   <= HALF_TC;
                    end
                end
                S_START: begin
                    if (cnt_q == '0) begin
                        if (!sync2_q) begin
                            state_q <= S_DATA;
                            cnt_q   <= FULL_TC;
                            bit_q   <= '0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == '0) begin
                        shift_q <= {sync2_q, shift_q[7:1]};
                        cnt_q   <= FULL_TC;
                        if (bit_q == 3'd7) begin
                            state_q <= S_STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_STOP: begin
                    if (cnt_q == '0) begin
                        if (sync2_q) begin
                            rx_byte_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                            state_q    <= S_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_WAIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    if (sync2_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    cmd_t       cmd_q, cmd_d;
    logic       idx_q, idx_d;
    logic [6:0] note_q, note_d;
    logic [6:0] key1_q, key1_d;
    logic [6:0] key2_q, key2_d;
    logic       ready_q, ready_d;
    logic       chan_ok;

    assign chan_ok = OMNI || (rx_byte_q[3:0] == CH_NIB);

    always_comb begin
        cmd_d  = cmd_q;
        idx_d  = idx_q;
        note_d = note_q;
        key1_d = key1_q;
        key2_d = key2_q;
        if (rx_valid_q) begin
            if (rx_byte_q[7]) begin
                // realtime bytes (F8-FF) leave running status untouched
                if (rx_byte_q[7:3] != 5'b11111) begin
                    if (chan_ok && rx_byte_q[7:4] == 4'h9) begin
                        cmd_d = CMD_ON;
                        idx_d = 1'b0;
                    end else if (chan_ok && rx_byte_q[7:4] == 4'h8) begin
                        cmd_d = CMD_OFF;
                        idx_d = 1'b0;
                    end else begin
                        cmd_d = CMD_NONE;
                    end
                end
            end else if (cmd_q != CMD_NONE) begin
                if (!idx_q) begin
                    note_d = rx_byte_q[6:0];
                    idx_d  = 1'b1;
                end else begin
                    idx_d = 1'b0;
                    if (note_q != 7'd0) begin
                        if (cmd_q == CMD_ON && rx_byte_q[6:0] != 7'd0) begin
                            if (note_q != key1_q && note_q != key2_q) begin
                                if (key1_q == 7'd0) begin
                                    key1_d = note_q;
                                end else if (key2_q == 7'd0) begin
                                    key2_d = note_q;
                                end
                            end
                        end else if (key2_q == note_q) begin
                            key2_d = 7'd0;
                        end else if (key1_q == note_q) begin
                            key1_d = key2_q;
                            key2_d = 7'd0;
                        end
                    end
                end
            end
        end
        ready_d = (key1_d != key1_q) || (key2_d != key2_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_q   <= CMD_NONE;
            idx_q   <= 1'b0;
            note_q  <= '0;
            key1_q  <= '0;
            key2_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            cmd_q   <= cmd_d;
            idx_q   <= idx_d;
            note_q  <= note_d;
            key1_q  <= key1_d;
            key2_q  <= key2_d;
            ready_q <= ready_d;
        end
    end

    assign key1_index = key1_q;
    assign key2_index = key2_q;
    assign midi_ready = ready_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_midi_key_rx.sv
// Bench for midi_key_rx: directed vector table, corner-case sequences, then
// random MIDI byte streams checked against a held-note list model.
module tb_midi_key_rx;

    localparam int CPB = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       midi_in = 1'b1;
    logic [6:0] key1_index, key2_index;
    logic       midi_ready, frame_err;

    midi_key_rx #(.CLKS_PER_BIT(CPB), .CHANNEL(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .midi_in    (midi_in),
        .key1_index (key1_index),
        .key2_index (key2_index),
        .midi_ready (midi_ready),
        .frame_err  (frame_err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    int ready_cnt = 0;
    int ready_cyc = 0;
    int ferr_cnt = 0;
    int stop_start_cyc = 0;
    int nchecks = 0;
    int nerr = 0;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (midi_ready) begin
            ready_cnt++;
            ready_cyc = cyc;
        end
        if (frame_err) ferr_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        midi_in = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            midi_in = b[i];
            wait_cycles(CPB);
        end
        stop_start_cyc = cyc;
        midi_in = stop_ok;
        wait_cycles(CPB);
        if (stop_ok) midi_in = 1'b1;
    endtask

    // Reference: running status plus an ordered list of at most two held notes
    int m_status = 0;   // 0 none, 1 note-on, 2 note-off
    bit m_have_note = 0;
    int m_note = 0;
    int held[$];

    function automatic int m_key(input int slot);
        return (held.size() > slot) ? held[slot] : 0;
    endfunction

    function automatic bit model_byte(input int b);
        int k1, k2, vel;
        bit is_on, found;
        k1 = m_key(0);
        k2 = m_key(1);
        if (b >= 'hF8) return 0;
        if (b >= 'h80) begin
            if (b / 16 == 9) m_status = 1;
            else if (b / 16 == 8) m_status = 2;
            else m_status = 0;
            m_have_note = 0;
            return 0;
        end
        if (m_status == 0) return 0;
        if (!m_have_note) begin
            m_note = b;
            m_have_note = 1;
            return 0;
        end
        m_have_note = 0;
        vel = b;
        if (m_note == 0) return 0;
        is_on = (m_status == 1) && (vel != 0);
        found = 0;
        foreach (held[i]) if (held[i] == m_note) found = 1;
        if (is_on) begin
            if (!found && held.size() < 2) held.push_back(m_note);
        end else begin
            for (int i = held.size() - 1; i >= 0; i--)
                if (held[i] == m_note) held.delete(i);
        end
        return (m_key(0) != k1) || (m_key(1) != k2);
    endfunction

    function automatic void model_reset();
        m_status = 0;
        m_have_note = 0;
        m_note = 0;
        held.delete();
    endfunction

    task automatic send_checked(input logic [7:0] b, input string tag);
        int r0, f0;
        bit chg;
        r0 = ready_cnt;
        f0 = ferr_cnt;
        chg = model_byte(int'(b));
        send_byte(b, 1'b1);
        chk({tag, " key1"}, int'(key1_index), m_key(0));
        chk({tag, " key2"}, int'(key2_index), m_key(1));
        chk({tag, " ready"}, ready_cnt - r0, int'(chg));
        chk({tag, " ferr"}, ferr_cnt - f0, 0);
    endtask

    typedef struct {
        logic [7:0] b;
        int         k1;
        int         k2;
        int         rdy;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int r0, f0;
        logic [7:0] rb;

        tbl[0]  = '{8'h90, 0, 0, 0};
        tbl[1]  = '{8'h3C, 0, 0, 0};
        tbl[2]  = '{8'h40, 60, 0, 1};
        tbl[3]  = '{8'h3E, 60, 0, 0};
        tbl[4]  = '{8'h40, 60, 62, 1};
        tbl[5]  = '{8'h40, 60, 62, 0};
        tbl[6]  = '{8'h40, 60, 62, 0};
        tbl[7]  = '{8'h80, 60, 62, 0};
        tbl[8]  = '{8'h3C, 60, 62, 0};
        tbl[9]  = '{8'h00, 62, 0, 1};
        tbl[10] = '{8'h90, 62, 0, 0};
        tbl[11] = '{8'h3E, 62, 0, 0};
        tbl[12] = '{8'h00, 0, 0, 1};
        tbl[13] = '{8'h90, 0, 0, 0};
        tbl[14] = '{8'h3C, 0, 0, 0};
        tbl[15] = '{8'hF8, 0, 0, 0};
        tbl[16] = '{8'h40, 60, 0, 1};

        wait_cycles(4);
        chk("reset key1", int'(key1_index), 0);
        chk("reset key2", int'(key2_index), 0);
        chk("reset ready", int'(midi_ready), 0);
        chk("reset ferr", int'(frame_err), 0);
        reset = 1'b0;
        wait_cycles(2 * CPB);

        for (int i = 0; i < 17; i++) begin
            r0 = ready_cnt;
            f0 = ferr_cnt;
            void'(model_byte(int'(tbl[i].b)));
            send_byte(tbl[i].b, 1'b1);
            chk($sformatf("tbl[%0d] key1", i), int'(key1_index), tbl[i].k1);
            chk($sformatf("tbl[%0d] key2", i), int'(key2_index), tbl[i].k2);
            chk($sformatf("tbl[%0d] ready", i), ready_cnt - r0, tbl[i].rdy);
            chk($sformatf("tbl[%0d] ferr", i), ferr_cnt - f0, 0);
            if (i == 2) begin
                nchecks++;
                if (ready_cyc - stop_start_cyc < CPB / 2 || ready_cyc - stop_start_cyc > CPB / 2 + 5) begin
                    nerr++;
                    $display("FAIL ready latency: pulse %0d cycles into stop bit, expected %0d..%0d",
                             ready_cyc - stop_start_cyc, CPB / 2, CPB / 2 + 5);
                end
            end
        end

        // Framing error: stop bit low, then line held low for 40 cycles
        r0 = ready_cnt;
        f0 = ferr_cnt;
        send_byte(8'h55, 1'b0);
        wait_cycles(40);
        chk("ferr pulse", ferr_cnt - f0, 1);
        chk("ferr key1", int'(key1_index), 60);
        chk("ferr key2", int'(key2_index), 0);
        chk("ferr ready", ready_cnt - r0, 0);
        midi_in = 1'b1;
        wait_cycles(2 * CPB);
        send_checked(8'h80, "ferr off status");
        send_checked(8'h3C, "ferr off note");
        send_checked(8'h00, "ferr off vel");
        send_checked(8'h90, "resend status");
        send_checked(8'h3C, "resend note");
        send_checked(8'h40, "resend vel");
        chk("resend key1 is 60", int'(key1_index), 60);

        // 4-cycle glitch must not start a byte
        r0 = ready_cnt;
        f0 = ferr_cnt;
        midi_in = 1'b0;
        wait_cycles(4);
        midi_in = 1'b1;
        wait_cycles(12 * CPB);
        chk("glitch ready", ready_cnt - r0, 0);
        chk("glitch ferr", ferr_cnt - f0, 0);
        chk("glitch key1", int'(key1_index), 60);
        send_checked(8'h3E, "post-glitch note");
        send_checked(8'h40, "post-glitch vel");

        // Reset in the middle of the data bits
        midi_in = 1'b0;
        wait_cycles(4 * CPB);
        reset = 1'b1;
        midi_in = 1'b1;
        wait_cycles(3);
        chk("midreset key1", int'(key1_index), 0);
        chk("midreset key2", int'(key2_index), 0);
        chk("midreset ready", int'(midi_ready), 0);
        chk("midreset ferr", int'(frame_err), 0);
        reset = 1'b0;
        model_reset();
        wait_cycles(2 * CPB);
        send_checked(8'h90, "after reset status");
        send_checked(8'h3E, "after reset note");
        send_checked(8'h40, "after reset vel");
        chk("after reset key1 is 62", int'(key1_index), 62);

        // Random stream biased toward few notes so slots collide and fill up
        for (int n = 0; n < 160; n++) begin
            case ($urandom_range(0, 9))
                0, 1: rb = 8'h90 | 8'($urandom_range(0, 15));
                2:    rb = 8'h80 | 8'($urandom_range(0, 15));
                3:    rb = 8'($urandom_range('hF8, 'hFF));
                4:    rb = 8'($urandom_range('hA0, 'hF7));
                default: rb = 8'($urandom_range(0, 6));
            endcase
            send_checked(rb, $sformatf("rand[%0d] 0x%02h", n, rb));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule

// File: doc/midi_key_rx.md
MIDI_KEY_RX -- requirements
Module: midi_key_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 2080, meaning clock cycles per MIDI bit (65 MHz / 31250 baud).
REQ-002 Parameter CHANNEL, default 16, meaning accepted MIDI channel 0-15; 16 means omni (all channels).
REQ-003 Port clock, input, 1, meaning the single system clock; all logic is on the rising edge.
REQ-004 Port reset, input, 1, meaning synchronous active-high reset.
REQ-005 Port midi_in, input, 1, meaning asynchronous serial MIDI line, idle high, 8N1, LSB first.
REQ-006 Port key1_index, output, 7, meaning first held note number; 0 means no key.
REQ-007 Port key2_index, output, 7, meaning second held note number; 0 means no key.
REQ-008 Port midi_ready, output, 1, meaning one-cycle pulse when key1_index/key2_index change.
REQ-009 Port frame_err, output, 1, meaning one-cycle pulse when a stop bit is sampled low.

Function
REQ-010 midi_in shall pass through a 2-flop synchronizer before any use.
REQ-011 The UART shall use states IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE -> START on a synchronized falling edge.
REQ-012 START shall sample at CLKS_PER_BIT/2 cycles (integer division).
- Sample low -> DATA.
- Sample high -> IDLE; the glitch is discarded.
REQ-013 DATA shall sample 8 bits at CLKS_PER_BIT intervals, LSB first; then -> STOP.
REQ-014 STOP shall sample one interval after bit 7.
- High: byte is valid for exactly one cycle; -> IDLE.
- Low: frame_err pulses that cycle; byte is discarded; -> WAIT_HIGH.
REQ-015 WAIT_HIGH shall return to IDLE only after a synchronized high is seen.
REQ-016 The parser shall track running status (cmd: none, on, off), a data index (0/1) and a latched note number.
REQ-017 Status bytes:
- 0x9n / 0x8n with n matching CHANNEL (or omni): set cmd to on / off, data index 0.
- Other 0x80-0xEF and 0xF0-0xF7: set cmd to none.
- 0xF8-0xFF (realtime): ignored; cmd and data index unchanged.
REQ-018 Data bytes (bit 7 clear) while cmd is none shall be ignored.
REQ-019 Data byte at index 0 shall latch the note and set index 1.
- Index 1 is velocity; it executes the command and sets index 0 (running status).
REQ-020 Note-on with velocity 0 shall be treated as note-off.
REQ-021 Note number 0 shall be ignored for both on and off.
REQ-022 Note-on rules:
- Note already in either slot: no change.
- Otherwise fill key1 if empty, else key2 if empty.
- Both slots full: the note is dropped.
REQ-023 Note-off rules:
- Matching key2: clear key2.
- Matching key1: key1 <= key2, key2 <= 0.
- No match: no change.
REQ-024 Slot update shall occur on the cycle after the valid byte. midi_ready shall pulse on that same cycle only if either slot value changed.
REQ-025 Maximum latency from stop-bit sample to midi_ready shall be 1 clock.
REQ-026 Bytes are at least 10 bit-times apart. No back-pressure exists and no byte queueing is required.

Reset
REQ-027 While reset is high, every register shall be cleared:
- UART state = IDLE, bit and clock counters = 0, synchronizer flops = 1.
- cmd = none, data index = 0.
- key1_index = key2_index = 0, midi_ready = 0, frame_err = 0.
REQ-028 Reset asserted mid-byte shall abandon the byte. After release, a byte shall be accepted only after a fresh start edge.

Verification (CLKS_PER_BIT=16, CHANNEL=16)
REQ-029 Send 0x90 0x3C 0x40 -> key1=60, key2=0; one midi_ready pulse 1 cycle after the third stop sample.
REQ-030 Then send 0x3E 0x40 (running status), then 0x40 0x40 -> key1=60, key2=62; third note dropped; exactly one midi_ready pulse in total.
REQ-031 Then send 0x80 0x3C 0x00 -> key1=62, key2=0, midi_ready pulse; then 0x90 0x3E 0x00 -> both 0.
REQ-032 Send 0x90 0x3C, then 0xF8, then 0x40 -> key1=60; the realtime byte does not disturb the sequence.
REQ-033 Drive the stop bit low on a byte -> frame_err one pulse, keys unchanged. Hold the line low for 40 cycles, then resend a valid 0x90 0x3C 0x40 -> key1=60.
REQ-034 Pulse midi_in low for 4 cycles -> no byte received. Assert reset mid-DATA -> all outputs 0, and the next full message is decoded correctly.
